cbg_bank_responder: RTL and testbench

//  Bank-group-side endpoint of the LSU->CBG crossbar. Takes one crossbar lane
//  (L_to_C_bus = {wdata, rd_req, addr}), buffers requests in order, executes

---
 rtl/cbg_bank_responder_pkg.sv | 45 ++++
 rtl/cbg_req_fifo.sv | 73 +++++++
 rtl/cbg_bank_responder.sv | 173 +++++++++++++++++
 tb/tb_cbg_bank_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cbg_bank_responder_pkg.sv
// cbg_bank_responder_pkg
//   Shared widths for the LSU->CBG crossbar lanes plus the small helpers used by
//   the bank-group responder.
//   The lane widths are also exported as the legacy text macros `W_d, `A_W,
//   `L_C_bus and `C_L_bus, together with the field offsets used to slice the
//   buses, so older crossbar files keep working.
//   Lane layouts:
//     L_C_bus : {wdata[`W_d], rd_req, addr[`A_W]}
//     C_L_bus : {rsp_valid, rsp_data[`W_d]}
//   Optional feature macro seen by users of this package: CBG_PARITY_EN.

`ifndef CBG_PARAM_DEFINE
`define CBG_PARAM_DEFINE
`define W_d         16
`define A_W         8
`define L_C_bus     (`W_d + 1 + `A_W)
`define C_L_bus     (`W_d + 1)
// Field offsets inside L_C_bus.
`define LC_ADDR_LSB 0
`define LC_RD_BIT   (`A_W)
`define LC_WD_LSB   (`A_W + 1)
// Field offsets inside C_L_bus.
`define CL_DATA_LSB 0
`define CL_VLD_BIT  (`W_d)
`endif

package cbg_bank_responder_pkg;

    localparam int CBG_W_D = `W_d;
    localparam int CBG_A_W = `A_W;
    localparam int L_C_W   = `L_C_bus;
    localparam int C_L_W   = `C_L_bus;

    // Response lane as seen by the crossbar.
    typedef struct packed {
        logic               valid;
        logic [CBG_W_D-1:0] data;
    } cbg_rsp_t;

    // Even parity: the stored bit makes the total number of ones even.
    function automatic logic even_par(input logic [CBG_W_D-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/cbg_req_fifo.sv
// cbg_req_fifo
//   Small synchronous FIFO holding queued bank requests in arrival order.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset
//     push_i/din_i  write request and data (ignored while full)
//     pop_i/dout_o  read request (ignored while empty); dout_o shows the head
//     full_o        count == depth
//     empty_o       count == 0
//     count_o       occupancy, AW+1 bits
//   Pointers wrap naturally modulo 2**AW.

module cbg_req_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
        else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/cbg_bank_responder.sv
// cbg_bank_responder
//   Bank-group endpoint of the LSU->CBG crossbar. Requests from one crossbar
//   lane are queued in order, executed one per cycle against a local word
//   array, and read data returns on the response lane RD_LAT cycles after the
//   request leaves the queue.
//   Ports:
//     clk, rst     clock, asynchronous active-high reset
//     L_to_C_bus   {wdata, rd_req, addr} request lane
//     wr_req       write strobe accompanying L_to_C_bus
//     full         request queue full; requests arriving now are dropped
//     R_response   {rsp_valid, rsp_data}; data forced to 0 when not valid
//     ovf          sticky: a request was dropped because the queue was full
//     proto_err    sticky: rd_req and wr_req arrived together (run as a write)
//     par_err      sticky: stored parity mismatch seen on a read response
//   Build option: CBG_PARITY_EN adds a parity bit per word and drives par_err;
//   without it par_err is constant 0.

module cbg_bank_responder
    import cbg_bank_responder_pkg::*;
#(
    parameter int BANK_AW = 6,
    parameter int FIFO_AW = 2,
    parameter int RD_LAT  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [`L_C_bus-1:0] L_to_C_bus,
    input  logic                wr_req,
    output logic                full,
    output logic [`C_L_bus-1:0] R_response,
    output logic                ovf,
    output logic                proto_err,
    output logic                par_err
);

    localparam int DEPTH = 1 << BANK_AW;
    localparam int ENT_W = CBG_W_D + 2 + BANK_AW;
`ifdef CBG_PARITY_EN
    localparam int MEM_W = CBG_W_D + 1;
`else
    localparam int MEM_W = CBG_W_D;
`endif

    // ---------------- request lane decode ----------------
    logic [CBG_W_D-1:0] req_wdata;
    logic               req_rd;
    logic [BANK_AW-1:0] req_addr;
    logic               req_any;

    assign req_wdata = L_to_C_bus[`LC_WD_LSB +: `W_d];
    assign req_rd    = L_to_C_bus[`LC_RD_BIT];
    assign req_addr  = L_to_C_bus[`LC_ADDR_LSB +: BANK_AW];
    assign req_any   = req_rd | wr_req;

    // ---------------- request queue ----------------
    logic [ENT_W-1:0] push_entry, pop_entry;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FIFO_AW:0] fifo_count;

    // A simultaneous rd+wr is queued as a pure write.
    assign push_entry = {req_wdata, req_rd & ~wr_req, wr_req, req_addr};
    // full comes from the registered count, so a push in a full cycle is lost
    // even when the same cycle also pops.
    assign fifo_push  = req_any & ~fifo_full;
    assign fifo_pop   = ~fifo_empty;
    assign full       = fifo_full;

    cbg_req_fifo #(
        .DW (ENT_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .din_i   (push_entry),
        .pop_i   (fifo_pop),
        .dout_o  (pop_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // ---------------- issue to the array ----------------
    logic [CBG_W_D-1:0] pop_wdata;
    logic [BANK_AW-1:0] pop_addr;
    logic               do_wr, do_rd;
    logic [MEM_W-1:0]   wr_word;

    assign pop_wdata = pop_entry[BANK_AW+2 +: CBG_W_D];
    assign pop_addr  = pop_entry[BANK_AW-1:0];
    assign do_wr     = fifo_pop & pop_entry[BANK_AW];
    assign do_rd     = fifo_pop & pop_entry[BANK_AW+1];

`ifdef CBG_PARITY_EN
    assign wr_word = {even_par(pop_wdata), pop_wdata};
`else
    assign wr_word = pop_wdata;
`endif

    logic [MEM_W-1:0] mem_q [DEPTH];

    // Array contents survive reset; a write lands at its pop edge so the next
    // popped read to the same address already sees it.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[pop_addr] <= wr_word;
    end

    // ---------------- read pipeline ----------------
    // Stage 0 is the registered array read; later stages only add delay.
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [MEM_W-1:0]  dat_q [RD_LAT];

    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = do_rd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    always_ff @(posedge clk) begin
        if (do_rd) dat_q[0] <= mem_q[pop_addr];
        for (int i = 1; i < RD_LAT; i++) dat_q[i] <= dat_q[i-1];
    end

    logic             rsp_valid;
    logic [MEM_W-1:0] rsp_word;
    cbg_rsp_t         rsp;

    assign rsp_valid  = vld_q[RD_LAT-1];
    assign rsp_word   = dat_q[RD_LAT-1];
    assign rsp.valid  = rsp_valid;
    assign rsp.data   = rsp_valid ? rsp_word[CBG_W_D-1:0] : '0;
    assign R_response = rsp;

    // ---------------- sticky error flags ----------------
    logic ovf_q, proto_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q   <= 1'b0;
            proto_q <= 1'b0;
        end else begin
            ovf_q   <= ovf_q | (req_any & fifo_full);
            proto_q <= proto_q | (req_rd & wr_req);
        end
    end

    assign ovf       = ovf_q;
    assign proto_err = proto_q;

`ifdef CBG_PARITY_EN
    logic par_q;

    // Checked at the output stage; the data itself is passed through as stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_q <= 1'b0;
        else     par_q <= par_q |
                          (rsp_valid & (even_par(rsp_word[CBG_W_D-1:0]) != rsp_word[CBG_W_D]));
    end

    assign par_err = par_q;
`else
    assign par_err = 1'b0;
`endif

    // Upper lane address bits and the queue occupancy are intentionally unused.
    logic unused_ok;
    assign unused_ok = ^{fifo_count, L_to_C_bus[`A_W-1:BANK_AW]};

endmodule

// File: tb/tb_cbg_bank_responder.sv
module tb_cbg_bank_responder;
    import cbg_bank_responder_pkg::*;

    localparam int RD_LAT = 2;
    localparam int QDEPTH = 4;
    localparam int BANKD  = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [L_C_W-1:0] bus = '0;
    logic             wr_req = 1'b0;
    logic             full;
    logic [C_L_W-1:0] rsp;
    logic             ovf, proto_err, par_err;

    always #5 clk = ~clk;

    cbg_bank_responder #(
        .BANK_AW (6),
        .FIFO_AW (2),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .L_to_C_bus (bus),
        .wr_req     (wr_req),
        .full       (full),
        .R_response (rsp),
        .ovf        (ovf),
        .proto_err  (proto_err),
        .par_err    (par_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    typedef struct {
        bit          rd;
        bit          wr;
        int          addr;
        logic [15:0] data;
    } mreq_t;

    mreq_t       q[$];
    logic [15:0] m_data [BANKD];
    bit          m_par  [BANKD];   // parity the bank stored for the last write
    logic [16:0] exp_rsp [int];    // keyed by clock-edge number
    bit          exp_bad [int];
    int          edge_n  = 0;
    bit          m_ovf = 0, m_proto = 0, m_par_err = 0;
    bit          stall = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge of the model, seen with the inputs present before the edge.
    task automatic model_edge(input bit rd, input bit wr, input int addr, input logic [15:0] data);
        bit    was_full;
        mreq_t p;
        mreq_t n;
        was_full = (q.size() == QDEPTH);
        if (!stall && q.size() > 0) begin
            p = q.pop_front();
            if (p.wr) begin
                m_data[p.addr] = p.data;
                m_par[p.addr]  = ^p.data;
            end else if (p.rd) begin
                exp_rsp[edge_n + RD_LAT - 1] = {1'b1, m_data[p.addr]};
                exp_bad[edge_n + RD_LAT - 1] = ((^m_data[p.addr]) != m_par[p.addr]);
            end
        end
        if (rd || wr) begin
            if (was_full) m_ovf = 1;
            else begin
                n.rd = rd && !wr; n.wr = wr; n.addr = addr % BANKD; n.data = data;
                q.push_back(n);
            end
        end
        if (rd && wr) m_proto = 1;
    endtask

    task automatic compare_outputs(input string tag);
        logic [16:0] e;
        e = exp_rsp.exists(edge_n) ? exp_rsp[edge_n] : 17'h0;
`ifdef CBG_PARITY_EN
        if (exp_bad.exists(edge_n) && exp_bad[edge_n]) m_par_err = 1;
`endif
        check({tag, ".rsp"},   32'(rsp), 32'(e));
        check({tag, ".full"},  32'(full), 32'(q.size() == QDEPTH));
        check({tag, ".ovf"},   32'(ovf), 32'(m_ovf));
        check({tag, ".proto"}, 32'(proto_err), 32'(m_proto));
        check({tag, ".par"},   32'(par_err), 32'(m_par_err));
    endtask

    task automatic cycle(input string tag, input bit rd, input bit wr, input int addr,
                         input logic [15:0] data);
        logic [7:0] a8;
        a8 = addr[7:0];
        bus    = {data, rd, a8};
        wr_req = wr;
        @(posedge clk);
        edge_n++;
        model_edge(rd, wr, addr, data);
        #1;
        compare_outputs(tag);
        if (rd || wr) $display("[TB] %s rd=%0d wr=%0d addr=%0d data=%h rsp=%h", tag, rd, wr, addr, data, rsp);
        bus    = '0;
        wr_req = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 0, 0, 0, 16'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".rsp"},   32'(rsp), 32'h0);
        check({tag, ".full"},  32'(full), 32'h0);
        check({tag, ".ovf"},   32'(ovf), 32'h0);
        check({tag, ".proto"}, 32'(proto_err), 32'h0);
        check({tag, ".par"},   32'(par_err), 32'h0);
    endtask

    // Asynchronous reset asserted between edges; everything queued or in flight is lost.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        #1 check_all_zero({tag, ".async"});
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            edge_n++;
            #1 check_all_zero({tag, ".hold"});
        end
        rst = 1'b0;
        q.delete();
        exp_rsp.delete();
        exp_bad.delete();
        m_ovf = 0; m_proto = 0; m_par_err = 0;
        $display("[TB] %s reset applied", tag);
    endtask

    initial begin
        int r, a;
        bit rd, wr;
        logic [15:0] d;

        // Reset state
        @(posedge clk);
        #1 check_all_zero("reset");
        rst = 1'b0;

        // Fill the whole bank so every later read has a known value.
        for (int i = 0; i < BANKD; i++) begin
            d = (i < 4) ? 16'(10 + i) : 16'($urandom);
            cycle("prefill", 0, 1, i, d);
        end

        // 1: write then read
        cycle("t1_wr", 0, 1, 5, 16'hA5A5);
        cycle("t1_rd", 1, 0, 5, 16'h0);
        idle("t1_wait", 4);

        // 2: four back-to-back reads
        for (int i = 0; i < 4; i++) cycle("t2_rd", 1, 0, i, 16'h0);
        idle("t2_wait", 4);

        // 4: rd+wr together acts as a write only
        cycle("t4_both", 1, 1, 7, 16'h003C);
        idle("t4_gap", 1);
        cycle("t4_rd", 1, 0, 7, 16'h0);
        idle("t4_wait", 4);

        // 3: queue held with no pops; fifth request is dropped
        force dut.fifo_pop = 1'b0;
        stall = 1;
        for (int i = 0; i < 5; i++) cycle("t3_push", 0, 1, 40 + i, 16'(16'h1000 + i));
        idle("t3_held", 1);
        release dut.fifo_pop;
        stall = 0;
        idle("t3_drain", 6);
        for (int i = 0; i < 5; i++) cycle("t3_rdback", 1, 0, 40 + i, 16'h0);
        idle("t3_wait", 4);

        // Randomized traffic, upper address bits included
        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 99);
            a  = $urandom_range(0, 255);
            d  = 16'($urandom);
            rd = (r < 35) || (r >= 95);
            wr = (r >= 35 && r < 70) || (r >= 95);
            cycle("rand", rd, wr, a, d);
        end
        idle("rand_wait", 6);

        // 6: parity corruption
`ifdef CBG_PARITY_EN
        dut.mem_q[9][0] = ~dut.mem_q[9][0];
        m_data[9][0]    = ~m_data[9][0];
`endif
        cycle("t6_rd", 1, 0, 9, 16'h0);
        idle("t6_wait", 4);

        // 5: reset with two reads in flight
        cycle("t5_rd", 1, 0, 1, 16'h0);
        cycle("t5_rd", 1, 0, 2, 16'h0);
        do_reset("t5");
        idle("t5_after", 6);
        cycle("t5_post_rd", 1, 0, 5, 16'h0);
        idle("t5_post_wait", 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
